// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 slave that behaves like a tiny serial flash. It decodes WREN
//   (06), WRDI (04), RDSR (05), READ (03) and PAGE PROGRAM (02), keeps its
//   contents in an internal byte array and models the WEL/WIP status bits.
//   The SPI pins are synchronised into the clk domain, so clk must run at
//   least 8x faster than spi_clk.
// Parameters
//   MEM_AW       memory address bits (depth 2**MEM_AW); low bits of the 16-bit address
//   PROG_CYCLES  clk cycles WIP stays high after a program completes (>=1)
// Ports
//   clk       in   system clock
//   nreset    in   asynchronous reset, active high
//   spi_clk   in   SPI clock from master, idle low
//   spi_cs    in   chip select, active low
//   spi_mosi  in   master-to-slave data, MSB first
//   spi_miso  out  slave-to-master data, MSB first
//   wip       out  write-in-progress status bit
//   wel       out  write-enable-latch status bit
module spi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int PROG_CYCLES = 64
) (
  input  logic clk,
  input  logic nreset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic wip,
  output logic wel
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, READ_DATA, PROG_DATA, STATUS, IGNORE
  } state_t;

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int WCW   = $clog2(PROG_CYCLES + 1);

  state_t            state, state_d, cur_state;
  logic [2:0]        sclk_sync, cs_sync;
  logic [1:0]        mosi_sync;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low, mosi_s;
  logic              bit_ev, fall_ev, byte_done;
  logic [7:0]        rx_byte, load_byte;
  logic [6:0]        shift_in, shift_out;
  logic [2:0]        bit_cnt;
  logic [MEM_AW-1:0] addr;
  logic              cmd_read, prog_any;
  logic [WCW-1:0]    wip_cnt;
  logic [7:0]        mem [DEPTH];

  // Two flops for metastability, the third holds the previous value for edge detection.
  // spi_cs resets to its idle-high level so release of reset never looks like a select.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], spi_cs};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_low    = ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: combinational blocks use blocking '=' so later lines see earlier results
  // within the same evaluation; state-holding blocks use '<=' only.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    cur_state = state;
    state_d   = state;
    byte_done = 1'b0;
    rx_byte   = {shift_in, mosi_s};
    load_byte = (state == READ_DATA) ? mem[addr] : {6'b0, wel, wip};
    // A select and a clock rise seen in the same cycle: the select is taken
    // first, so the rise already counts as bit 0 of the command.
    if (state == IDLE && cs_fall) cur_state = CMD;
    bit_ev  = sclk_rise && cs_low && cur_state != IDLE && cur_state != IGNORE;
    fall_ev = sclk_fall && cs_low && state != IDLE;
    state_d = cur_state;
    if (cs_rise) begin
      state_d = IDLE;
    end else if (bit_ev && bit_cnt == 3'd7) begin
      byte_done = 1'b1;
      case (cur_state)
        CMD: begin
          if (wip) state_d = (rx_byte == 8'h05) ? STATUS : IGNORE;
          else begin
            case (rx_byte)
              8'h05:   state_d = STATUS;
              8'h03:   state_d = ADDR_HI;
              8'h02:   state_d = wel ? ADDR_HI : IGNORE;
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR_HI: state_d = ADDR_LO;
        ADDR_LO: state_d = cmd_read ? READ_DATA : PROG_DATA;
        default: state_d = cur_state;
      endcase
    end
  end

  // NOTE: the memory array sits on the asynchronous reset because the device
  // must come out of every reset erased (all 8'hFF), like a blank flash part.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      spi_miso  <= 1'b0;
      wip       <= 1'b0;
      wel       <= 1'b0;
      wip_cnt   <= '0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      cmd_read  <= 1'b0;
      prog_any  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      if (wip) begin
        if (wip_cnt == '0) wip <= 1'b0;
        else               wip_cnt <= wip_cnt - 1'b1;
      end

      if (cs_rise) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
        prog_any <= 1'b0;
        if (state == PROG_DATA && prog_any) begin
          wip     <= 1'b1;
          wel     <= 1'b0;
          wip_cnt <= WCW'(PROG_CYCLES - 1);
        end
      end

      if (bit_ev) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= rx_byte[6:0];
        // The full 16-bit address streams through; only the last MEM_AW bits stay.
        if (cur_state == ADDR_HI || cur_state == ADDR_LO) addr <= {addr[MEM_AW-2:0], mosi_s};
        if (byte_done) begin
          case (cur_state)
            CMD: begin
              cmd_read <= (rx_byte == 8'h03);
              if (!wip && rx_byte == 8'h06) wel <= 1'b1;
              if (!wip && rx_byte == 8'h04) wel <= 1'b0;
            end
            READ_DATA: addr <= addr + MEM_AW'(1);
            PROG_DATA: begin
              mem[addr] <= mem[addr] & rx_byte;
              addr      <= addr + MEM_AW'(1);
              prog_any  <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (fall_ev) begin
        if (state == READ_DATA || state == STATUS) begin
          if (bit_cnt == 3'd0) begin
            spi_miso  <= load_byte[7];
            shift_out <= load_byte[6:0];
          end else begin
            spi_miso  <= shift_out[6];
            shift_out <= {shift_out[5:0], 1'b0};
          end
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI mode-0 transactions and
// compares received bytes and status pins against hand-computed values.
module tb_spi_flash_responder;

  localparam int PROG_CYC = 1000;
  localparam int HALF     = 8;    // clk cycles per spi_clk half period

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, wip, wel;

  int n_checks = 0;
  int n_fail   = 0;

  spi_flash_responder #(.MEM_AW(8), .PROG_CYCLES(PROG_CYC)) dut (
    .clk(clk), .nreset(nreset), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .wip(wip), .wel(wel)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      half_period();
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      half_period();
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    half_period();
  endtask

  task automatic cs_end();
    half_period();
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] d;
    cs_begin(); send(op, d); cs_end();
  endtask

  task automatic rdsr(output logic [7:0] st);
    logic [7:0] d;
    cs_begin(); send(8'h05, d); send(8'h00, st); cs_end();
  endtask

  task automatic read2(input logic [15:0] a, output logic [7:0] d0, output logic [7:0] d1);
    logic [7:0] d;
    cs_begin();
    send(8'h03, d); send(a[15:8], d); send(a[7:0], d);
    send(8'h00, d0); send(8'h00, d1);
    cs_end();
  endtask

  // Leaves cs low after the data so callers can measure the cs-rise response.
  task automatic prog_open(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input int nb);
    logic [7:0] d;
    cs_begin();
    send(8'h02, d); send(a[15:8], d); send(a[7:0], d);
    send(d0, d);
    if (nb > 1) send(d1, d);
  endtask

  task automatic prog(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input int nb);
    prog_open(a, d0, d1, nb);
    cs_end();
  endtask

  task automatic wait_wip_clear(input string name);
    int k = 0;
    while (wip === 1'b1 && k < 3 * PROG_CYC) begin @(negedge clk); k++; end
    n_checks++;
    if (wip !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: wip still %b after %0d cycles, expected 0", name, wip, k);
    end
  endtask

  task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] st;
    n_checks++;
    if ({spi_miso, wip, wel} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pins: got miso/wip/wel=%b expected 000", {spi_miso, wip, wel});
    end
    rdsr(st);
    expect8("rdsr_after_reset", st, 8'h00);
  endtask

  task automatic test_wel();
    logic [7:0] st;
    cmd1(8'h06);
    rdsr(st);
    expect8("rdsr_after_wren", st, 8'h02);
    cmd1(8'h04);
    rdsr(st);
    expect8("rdsr_after_wrdi", st, 8'h00);
  endtask

  task automatic test_prog_without_wren();
    logic [7:0] d0, d1;
    bit seen = 0;
    prog_open(16'h01AA, 8'h55, 8'h00, 1);
    half_period();
    spi_cs = 1'b1;
    repeat (20) begin @(negedge clk); if (wip) seen = 1; end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL pp_no_wren_wip: got wip=1 expected 0");
    end
    read2(16'h01AA, d0, d1);
    expect8("pp_no_wren_read", d0, 8'hFF);
  endtask

  task automatic test_program();
    logic [7:0] st, d0, d1;
    cmd1(8'h06);
    prog(16'h01AA, 8'h55, 8'h00, 1);
    rdsr(st);
    expect8("rdsr_during_wip", st, 8'h01);
    cmd1(8'h06);                  // must be ignored while busy
    wait_wip_clear("pp1_wip_clear");
    rdsr(st);
    expect8("rdsr_after_wip", st, 8'h00);
    read2(16'h01AA, d0, d1);
    expect8("read_01aa", d0, 8'h55);
  endtask

  task automatic test_and_and_wip_time();
    logic [7:0] d0, d1;
    int k, cnt;
    cmd1(8'h06);
    prog_open(16'h01AA, 8'hF0, 8'h00, 1);
    half_period();
    spi_cs = 1'b1;
    k = 0;
    while (wip !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    cnt = 0;
    while (wip === 1'b1 && cnt < 3 * PROG_CYC) begin @(negedge clk); cnt++; end
    n_checks++;
    if (cnt != PROG_CYC) begin
      n_fail++;
      $display("FAIL wip_duration: got %0d cycles expected %0d", cnt, PROG_CYC);
    end
    read2(16'h01AA, d0, d1);
    expect8("read_and_f0_55", d0, 8'h50);
  endtask

  task automatic test_wrap();
    logic [7:0] d0, d1;
    cmd1(8'h06);
    prog(16'h01FF, 8'h12, 8'h34, 2);
    wait_wip_clear("wrap_wip_clear");
    read2(16'h01FF, d0, d1);
    expect8("read_wrap_ff", d0, 8'h12);
    expect8("read_wrap_00", d1, 8'h34);
  endtask

  task automatic test_partial_byte();
    logic [7:0] st, d, d0, d1;
    bit seen = 0;
    cmd1(8'h06);
    cs_begin();
    send(8'h02, d); send(8'h01, d); send(8'h10, d);
    spi_bits(8'h00, 4, d);
    half_period();
    spi_cs = 1'b1;
    repeat (20) begin @(negedge clk); if (wip) seen = 1; end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL partial_wip: got wip=1 expected 0");
    end
    rdsr(st);
    expect8("partial_wel_kept", st, 8'h02);
    read2(16'h0110, d0, d1);
    expect8("partial_mem_unchanged", d0, 8'hFF);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, d0, d1;
    n_checks++;
    if (wel !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_wel: got %b expected 1", wel);
    end
    cs_begin();
    send(8'h03, d); send(8'h01, d); send(8'h10, d);
    spi_bits(8'h00, 3, d);
    expect8("pre_reset_read_bits", d, 8'h07);
    nreset = 1'b1;
    #1;
    n_checks++;
    if ({spi_miso, wel, wip} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_read: got miso/wel/wip=%b expected 000", {spi_miso, wel, wip});
    end
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    nreset = 1'b0;
    repeat (8) @(negedge clk);
    read2(16'h01AA, d0, d1);
    expect8("post_reset_01aa", d0, 8'hFF);
    read2(16'h01FF, d0, d1);
    expect8("post_reset_01ff", d0, 8'hFF);
    expect8("post_reset_0100", d1, 8'hFF);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    nreset = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_wel();
    test_prog_without_wren();
    test_program();
    test_and_and_wip_time();
    test_wrap();
    test_partial_byte();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
